// File: rtl/iob_ext_mem_arbiter_pkg.sv
// Shared types and helpers for the ext_mem round-robin arbiter.
// Pure declarations: no latency, no backpressure.
package iob_ext_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Requester index width; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_arbiter.sv
// Round-robin pick: first requester after i_last (wrapping), combinational.
// Zero latency; no backpressure, the caller decides when to sample o_grant.
module iob_rr_arbiter
    import iob_ext_mem_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_any
);

    logic [IDX_W-1:0] w_idx;

    // Walk from farthest to nearest so the candidate right after i_last wins.
    always_comb begin
        o_grant = '0;
        o_any   = |i_req;
        w_idx   = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_idx = IDX_W'((int'(i_last) + i) % N_REQ);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/iob_ext_mem_arbiter.sv
// Round-robin share of one IOb port among N_REQ requesters; optional watchdog via IOB_EXT_MEM_ARB_TIMEOUT_EN.
// 1-cycle arbitration, grant held through request + read response; backpressure is s_ready_i passed to the granted m_ready_o.
module iob_ext_mem_arbiter
    import iob_ext_mem_arbiter_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cke_i,
    input  logic [N_REQ-1:0]           m_avalid_i,
    input  logic [N_REQ*ADDR_W-1:0]    m_addr_i,
    input  logic [N_REQ*DATA_W-1:0]    m_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0]  m_wstrb_i,
    output logic [N_REQ-1:0]           m_ready_o,
    output logic [N_REQ-1:0]           m_rvalid_o,
    output logic [N_REQ*DATA_W-1:0]    m_rdata_o,
    output logic                       s_avalid_o,
    output logic [ADDR_W-1:0]          s_addr_o,
    output logic [DATA_W-1:0]          s_wdata_o,
    output logic [DATA_W/8-1:0]        s_wstrb_o,
    input  logic                       s_ready_i,
    input  logic                       s_rvalid_i,
    input  logic [DATA_W-1:0]          s_rdata_i,
    output logic                       timeout_o
);

    localparam int GW     = idx_width(N_REQ);
    localparam int STRB_W = DATA_W / 8;

    arb_state_t          r_state;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       r_last_grant;

    logic [GW-1:0]       w_arb_grant;
    logic                w_any_req;
    logic                w_sel_avalid;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [STRB_W-1:0]   w_sel_wstrb;
    logic                w_sel_write;
    logic                w_handshake;
    logic                w_expire;

    iob_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (GW)
    ) u_rr (
        .i_req   (m_avalid_i),
        .i_last  (r_last_grant),
        .o_grant (w_arb_grant),
        .o_any   (w_any_req)
    );

    assign w_sel_avalid = m_avalid_i[r_grant];
    assign w_sel_addr   = m_addr_i[r_grant*ADDR_W +: ADDR_W];
    assign w_sel_wdata  = m_wdata_i[r_grant*DATA_W +: DATA_W];
    assign w_sel_wstrb  = m_wstrb_i[r_grant*STRB_W +: STRB_W];
    assign w_sel_write  = |w_sel_wstrb;
    assign w_handshake  = (r_state == ST_REQ) && w_sel_avalid && s_ready_i;

`ifdef IOB_EXT_MEM_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;

    // Held at zero outside RESP, so every response wait starts from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (cke_i) begin
            if (r_state != ST_RESP) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_expire = (r_state == ST_RESP) && (&r_cnt) && !s_rvalid_i;
`else
    logic [TIMEOUT_W-1:0] w_timeout_unused;

    assign w_timeout_unused = '0;
    assign w_expire         = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(N_REQ - 1);
        end else if (cke_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_arb_grant;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_handshake) begin
                        r_last_grant <= r_grant;
                        r_state      <= w_sel_write ? ST_IDLE : ST_RESP;
                    end else if (!w_sel_avalid) begin
                        // Withdrawn request does not consume the requester's turn.
                        r_state <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (s_rvalid_i || w_expire) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_avalid_o = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
        m_ready_o  = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        timeout_o  = 1'b0;
        case (r_state)
            ST_REQ: begin
                s_avalid_o         = w_sel_avalid;
                s_addr_o           = w_sel_addr;
                s_wdata_o          = w_sel_wdata;
                s_wstrb_o          = w_sel_wstrb;
                m_ready_o[r_grant] = s_ready_i;
            end
            ST_RESP: begin
                // Real data beats the watchdog when both land in the same cycle.
                if (s_rvalid_i) begin
                    m_rvalid_o[r_grant]                  = 1'b1;
                    m_rdata_o[r_grant*DATA_W +: DATA_W]  = s_rdata_i;
                end else if (w_expire) begin
                    m_rvalid_o[r_grant]                  = 1'b1;
                    m_rdata_o[r_grant*DATA_W +: DATA_W]  = '1;
                    timeout_o                            = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iob_ext_mem_arbiter.sv
// Randomized bench for iob_ext_mem_arbiter against a transaction-level round-robin model.
module tb_iob_ext_mem_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TW = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cke_i;
    logic [NR-1:0]     m_avalid_i;
    logic [NR*AW-1:0]  m_addr_i;
    logic [NR*DW-1:0]  m_wdata_i;
    logic [NR*SW-1:0]  m_wstrb_i;
    logic [NR-1:0]     m_ready_o;
    logic [NR-1:0]     m_rvalid_o;
    logic [NR*DW-1:0]  m_rdata_o;
    logic              s_avalid_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_wdata_o;
    logic [SW-1:0]     s_wstrb_o;
    logic              s_ready_i;
    logic              s_rvalid_i;
    logic [DW-1:0]     s_rdata_i;
    logic              timeout_o;

    always #5 clk_i = ~clk_i;

    iob_ext_mem_arbiter #(
        .N_REQ     (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cke_i      (cke_i),
        .m_avalid_i (m_avalid_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_wstrb_i  (m_wstrb_i),
        .m_ready_o  (m_ready_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .s_avalid_o (s_avalid_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_wstrb_o  (s_wstrb_o),
        .s_ready_i  (s_ready_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i),
        .timeout_o  (timeout_o)
    );

    int n_run  = 0;
    int n_fail = 0;
    int last_g;

    logic          req_vld   [NR];
    logic [AW-1:0] req_addr  [NR];
    logic [DW-1:0] req_wdata [NR];
    logic [SW-1:0] req_strb  [NR];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < NR; k++) begin
            m_avalid_i[k]           = req_vld[k];
            m_addr_i[k*AW +: AW]    = req_addr[k];
            m_wdata_i[k*DW +: DW]   = req_wdata[k];
            m_wstrb_i[k*SW +: SW]   = req_strb[k];
        end
    endtask

    task automatic new_req(input int k, input bit wr);
        req_vld[k]   = 1'b1;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_strb[k]  = wr ? SW'($urandom_range(15, 1)) : '0;
    endtask

    // Next requester by round-robin rule: first pending one after the last served.
    function automatic int rr_pick();
        for (int i = 1; i <= NR; i++) begin
            if (req_vld[(last_g + i) % NR]) return (last_g + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] oh(input int k);
        logic [NR-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [NR*DW-1:0] rd_vec(input int k, input logic [DW-1:0] d);
        logic [NR*DW-1:0] v;
        v            = '0;
        v[k*DW +: DW] = d;
        return v;
    endfunction

    // Entered a little after a falling edge with the FSM idle and requests driven.
    // rv_dly < 0 means the memory never answers (watchdog path).
    task automatic run_txn(input int rdy_dly, input int rv_dly, input logic [DW-1:0] rdata, input bit stray);
        int  k;
        int  lim;
        bit  wr;
        k  = rr_pick();
        wr = (req_strb[k] != '0);
        s_ready_i  = 1'b0;
        s_rvalid_i = stray;
        s_rdata_i  = $urandom;
        #1;
        check("idle_quiet", {s_avalid_o, m_ready_o, m_rvalid_o, timeout_o}, '0);
        for (int d = 0; d <= rdy_dly; d++) begin
            @(negedge clk_i);
            s_ready_i  = (d == rdy_dly);
            s_rvalid_i = stray;
            #1;
            check("req_avalid", s_avalid_o, 1'b1);
            check("req_addr", s_addr_o, req_addr[k]);
            check("req_wdata", s_wdata_o, req_wdata[k]);
            check("req_wstrb", s_wstrb_o, req_strb[k]);
            check("req_ready", m_ready_o, s_ready_i ? oh(k) : '0);
            check("req_no_rvalid", {m_rvalid_o, timeout_o}, '0);
        end
        last_g = k;
        @(negedge clk_i);
        req_vld[k] = 1'b0;
        drive_reqs();
        s_ready_i  = 1'b0;
        s_rvalid_i = 1'b0;
        if (!wr) begin
            lim = (rv_dly < 0) ? (1 << TW) - 1 : rv_dly;
            for (int d = 0; d <= lim; d++) begin
                if (d > 0) @(negedge clk_i);
                s_rvalid_i = (rv_dly >= 0) && (d == rv_dly);
                s_rdata_i  = (d == lim) ? rdata : DW'($urandom);
                #1;
                check("resp_no_avalid", s_avalid_o, 1'b0);
                if (d < lim) begin
                    check("resp_wait", {m_rvalid_o, timeout_o}, '0);
                end else if (rv_dly >= 0) begin
                    check("resp_rvalid", m_rvalid_o, oh(k));
                    check("resp_rdata", m_rdata_o, rd_vec(k, rdata));
                    check("resp_no_timeout", timeout_o, 1'b0);
                end else begin
                    check("to_rvalid", m_rvalid_o, oh(k));
                    check("to_rdata", m_rdata_o, rd_vec(k, {DW{1'b1}}));
                    check("to_pulse", timeout_o, 1'b1);
                end
            end
            @(negedge clk_i);
            s_rvalid_i = 1'b0;
        end
        #1;
        check("back_idle", {s_avalid_o, m_ready_o, m_rvalid_o, timeout_o}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time budget exhausted");
        $fatal(1, "bench time limit");
    end

    initial begin
        int k;
        rst_i      = 1'b1;
        cke_i      = 1'b1;
        s_ready_i  = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        m_avalid_i = '0;
        m_addr_i   = '0;
        m_wdata_i  = '0;
        m_wstrb_i  = '0;
        for (int i = 0; i < NR; i++) begin
            req_vld[i]   = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_strb[i]  = '0;
        end
        drive_reqs();
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_ctrl", {s_avalid_o, m_ready_o, m_rvalid_o, timeout_o}, '0);
        check("rst_data", {s_addr_o, s_wdata_o, s_wstrb_o}, '0);
        check("rst_rdata", m_rdata_o, '0);
        rst_i  = 1'b0;
        last_g = NR - 1;

        // Single read by requester 0, data two cycles after accept.
        new_req(0, 1'b0);
        req_addr[0] = 32'h0000_0100;
        drive_reqs();
        run_txn(0, 1, 32'hCAFE_F00D, 1'b0);

        // Write by requester 1.
        new_req(1, 1'b1);
        req_wdata[1] = 32'h1234_5678;
        req_strb[1]  = 4'hF;
        drive_reqs();
        run_txn(0, 0, '0, 1'b0);

        // Stray read-valid while idle and requesting must never be forwarded.
        new_req(2, 1'b0);
        drive_reqs();
        run_txn(2, 2, $urandom, 1'b1);

        // Two requesters holding reads back to back.
        new_req(0, 1'b0);
        new_req(1, 1'b0);
        drive_reqs();
        for (int t = 0; t < 4; t++) begin
            k = rr_pick();
            run_txn(0, 0, $urandom, 1'b0);
            new_req(k, 1'b0);
            drive_reqs();
        end
        req_vld[0] = 1'b0;
        req_vld[1] = 1'b0;
        drive_reqs();

        // Request withdrawn before accept: turn is not consumed.
        @(negedge clk_i);
        new_req(0, 1'b0);
        drive_reqs();
        @(negedge clk_i);
        #1;
        check("drop_req_avalid", s_avalid_o, 1'b1);
        @(negedge clk_i);
        req_vld[0] = 1'b0;
        drive_reqs();
        #1;
        check("drop_avalid_low", {s_avalid_o, m_ready_o}, '0);
        @(negedge clk_i);
        new_req(0, 1'b0);
        new_req(1, 1'b1);
        drive_reqs();
        run_txn(1, 0, $urandom, 1'b0);
        run_txn(0, 0, $urandom, 1'b0);

        // Clock enable low freezes the idle state.
        new_req(2, 1'b1);
        drive_reqs();
        cke_i = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk_i);
            #1;
            check("cke_frozen", {s_avalid_o, m_ready_o}, '0);
        end
        cke_i = 1'b1;
        run_txn(0, 0, '0, 1'b0);

        // Reset while waiting for read data, then a late response.
        new_req(0, 1'b0);
        drive_reqs();
        @(negedge clk_i);
        s_ready_i = 1'b1;
        #1;
        check("rstresp_req", m_ready_o, oh(0));
        @(negedge clk_i);
        s_ready_i  = 1'b0;
        req_vld[0] = 1'b0;
        drive_reqs();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i      = 1'b0;
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hDEAD_BEEF;
        #1;
        check("rstresp_quiet", {s_avalid_o, m_ready_o, m_rvalid_o, timeout_o}, '0);
        check("rstresp_rdata", m_rdata_o, '0);
        last_g = NR - 1;
        @(negedge clk_i);
        s_rvalid_i = 1'b0;
        new_req(0, 1'b0);
        new_req(1, 1'b0);
        drive_reqs();
        run_txn(1, 2, $urandom, 1'b0);

`ifdef IOB_EXT_MEM_ARB_TIMEOUT_EN
        // Silent memory: watchdog answers; then data arriving on the expiry cycle wins.
        req_vld[1] = 1'b0;
        new_req(2, 1'b0);
        drive_reqs();
        run_txn(0, -1, '0, 1'b0);
        new_req(2, 1'b0);
        drive_reqs();
        run_txn(0, (1 << TW) - 1, 32'h5A5A_A5A5, 1'b0);
`endif

        for (int t = 0; t < 60; t++) begin
            for (int j = 0; j < NR; j++) begin
                if (!req_vld[j] && $urandom_range(1, 0) == 1) new_req(j, $urandom_range(1, 0) == 1);
            end
            if (rr_pick() < 0) new_req(int'($urandom_range(NR - 1, 0)), 1'b0);
            drive_reqs();
            run_txn(int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), $urandom,
                    $urandom_range(1, 0) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
